// File: rtl/aes_pkg.sv
// Shared types and default timing constants for the AES block-mode controller.
package aes_pkg;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        OUT
    } cbc_state_t;

    localparam int LOAD_CYCLES_DEF = 2;
    localparam int TIMEOUT_DEF     = 64;

endpackage

// File: rtl/aes_cbc_timer.sv
// Saturating down-counter shared by the core_load hold time and the WAIT timeout.
module aes_cbc_timer #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] preset,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load wins over enable; the count sticks at zero rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= preset;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/aes_cbc_ctrl.sv
// Handshake controller in front of an external AES-128 core.
// Define AES_CBC_EN for CBC chaining; the default build is ECB and ignores iv.
module aes_cbc_ctrl
    import aes_pkg::*;
#(
    parameter int LOAD_CYCLES = LOAD_CYCLES_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         iv_wr,
    input  logic [127:0] iv,
    input  logic [127:0] key,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic         core_load,
    output logic [127:0] core_key,
    output logic [127:0] core_plaintext,
    input  logic         core_done,
    input  logic [127:0] core_cyphertext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy,
    output logic         err_timeout
);

    localparam int TMAX = (TIMEOUT > LOAD_CYCLES) ? TIMEOUT : LOAD_CYCLES;
    localparam int CW   = $clog2(TMAX + 1);
    localparam logic [CW-1:0] LOAD_PRESET = CW'(LOAD_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_PRESET = CW'(TIMEOUT - 1);

    cbc_state_t      state;
    cbc_state_t      state_next;
    logic            first_wait;
    logic            accept;
    logic            capture;
    logic            timeout_hit;
    logic            timer_load;
    logic            timer_enable;
    logic            timer_zero;
    logic [CW-1:0]   timer_preset;
    block_t          mix;

    aes_cbc_timer #(.WIDTH(CW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .preset (timer_preset),
        .enable (timer_enable),
        .zero   (timer_zero)
    );

    // Done is only trusted after the first WAIT cycle so a level left over
    // from the previous block cannot complete this one.
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        capture      = 1'b0;
        timeout_hit  = 1'b0;
        timer_load   = 1'b0;
        timer_enable = 1'b0;
        timer_preset = WAIT_PRESET;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept       = 1'b1;
                    timer_load   = 1'b1;
                    timer_preset = LOAD_PRESET;
                    state_next   = LOAD;
                end
            end
            LOAD: begin
                if (timer_zero) begin
                    timer_load = 1'b1;
                    state_next = WAIT;
                end else begin
                    timer_enable = 1'b1;
                end
            end
            WAIT: begin
                if (core_done && !first_wait) begin
                    capture    = 1'b1;
                    state_next = OUT;
                end else if (timer_zero) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else begin
                    timer_enable = 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef AES_CBC_EN
    block_t chain;

    // A same-cycle iv write is bypassed so the new vector chains this block.
    assign mix = iv_wr ? block_t'(iv) : chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else if ((state == IDLE) && iv_wr) begin
            chain <= iv;
        end else if (capture) begin
            chain <= core_cyphertext;
        end
    end
`else
    logic unused_iv;

    assign mix       = '0;
    assign unused_iv = ^iv;
`endif

    // iv_wr doubles as the error acknowledge in both modes, but only in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            first_wait     <= 1'b0;
            err_timeout    <= 1'b0;
            core_plaintext <= '0;
            out_block      <= '0;
        end else begin
            state      <= state_next;
            first_wait <= (state == LOAD) && timer_zero;
            if ((state == IDLE) && iv_wr) begin
                err_timeout <= 1'b0;
            end else if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
            if (accept) begin
                core_plaintext <= in_block ^ mix;
            end
            if (capture) begin
                out_block <= core_cyphertext;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign core_load = (state == LOAD);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign core_key  = key;

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Scoreboard bench for aes_cbc_ctrl with a behavioural AES core stand-in.
// Follows AES_CBC_EN the same way the design does (CBC when defined, ECB otherwise).
module tb_aes_cbc_ctrl;

    localparam int TB_LOAD    = 2;
    localparam int TB_TIMEOUT = 64;
`ifdef AES_CBC_EN
    localparam bit CBC_MODE = 1'b1;
`else
    localparam bit CBC_MODE = 1'b0;
`endif
    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset;
    logic         iv_wr;
    logic [127:0] iv;
    logic [127:0] key;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         core_load;
    logic [127:0] core_key;
    logic [127:0] core_plaintext;
    logic         core_done;
    logic [127:0] core_cyphertext;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;
    logic         err_timeout;

    int           checkCount = 0;
    int           passCount  = 0;
    logic [127:0] ptQ[$];
    logic [127:0] ctQ[$];
    logic [127:0] modelChain;
    int           doneDelay = 22;
    bit           staleMode = 1'b0;
    bit           coreDead  = 1'b0;

    int           coreCnt;
    logic [127:0] latPt;
    logic [127:0] latKey;

    aes_cbc_ctrl #(.LOAD_CYCLES(TB_LOAD), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk             (clk),
        .reset           (reset),
        .iv_wr           (iv_wr),
        .iv              (iv),
        .key             (key),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_block        (in_block),
        .core_load       (core_load),
        .core_key        (core_key),
        .core_plaintext  (core_plaintext),
        .core_done       (core_done),
        .core_cyphertext (core_cyphertext),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_block       (out_block),
        .busy            (busy),
        .err_timeout     (err_timeout)
    );

    always #5 clk = ~clk;

    // Stand-in cipher: the FIPS-197 known answer, otherwise a keyed bijection.
    function automatic logic [127:0] coreCipher(input logic [127:0] pt, input logic [127:0] k);
        if (pt == KAT_PT && k == KAT_KEY) return KAT_CT;
        return {pt[118:0], pt[127:119]} ^ k ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Core model: done rises doneDelay cycles after load falls and stays high
    // until the next load; staleMode keeps it high into the first WAIT cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_done       <= 1'b0;
            core_cyphertext <= '0;
            coreCnt         <= 0;
        end else if (core_load) begin
            latPt   <= core_plaintext;
            latKey  <= core_key;
            coreCnt <= doneDelay;
            if (!staleMode) core_done <= 1'b0;
        end else if (coreCnt > 0) begin
            coreCnt <= coreCnt - 1;
            if (staleMode && coreCnt == doneDelay) core_done <= 1'b0;
            if (coreCnt == 1 && !coreDead) begin
                core_done       <= 1'b1;
                core_cyphertext <= coreCipher(latPt, latKey);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic checkFlag(input string name, input logic actual, input logic expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    endtask

    task automatic checkNumber(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Reference model: CBC is plaintext XOR previous ciphertext (or iv), ECB is plain.
    task automatic applyStimulus(input logic [127:0] blk, input bit doIv,
                                 input logic [127:0] ivVal, input bit expectOut);
        int n = 0;
        logic [127:0] pt;
        logic [127:0] ct;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkFlag("in_ready_before_send", in_ready, 1'b1);
        if (doIv && CBC_MODE) modelChain = ivVal;
        pt = CBC_MODE ? (blk ^ modelChain) : blk;
        ptQ.push_back(pt);
        if (expectOut) begin
            ct = coreCipher(pt, key);
            ctQ.push_back(ct);
            if (CBC_MODE) modelChain = ct;
        end
        in_valid = 1'b1;
        in_block = blk;
        iv_wr    = doIv;
        iv       = ivVal;
        @(negedge clk);
        in_valid = 1'b0;
        iv_wr    = 1'b0;
    endtask

    task automatic writeIv(input logic [127:0] v);
        iv_wr = 1'b1;
        iv    = v;
        if (CBC_MODE) modelChain = v;
        @(negedge clk);
        iv_wr = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy || ctQ.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkNumber("drain_pending", ctQ.size(), 0);
        checkFlag("drain_busy", busy, 1'b0);
    endtask

    task automatic waitOutValid();
        int n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkFlag("out_valid_arrives", out_valid, 1'b1);
    endtask

    task automatic waitLoadFall();
        int n = 0;
        while (!core_load && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (core_load && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Monitor: samples just after the driving edge, when inputs are settled.
    initial begin
        bit prevLoad = 1'b0;
        int loadCnt = 0;
        logic [127:0] curPt = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                prevLoad = 1'b0;
                loadCnt  = 0;
            end else begin
                if (core_load) begin
                    if (!prevLoad) begin
                        loadCnt = 0;
                        if (ptQ.size() == 0) checkFlag("spurious_core_load", core_load, 1'b0);
                        else curPt = ptQ.pop_front();
                        checkOutput("core_key", core_key, key);
                    end
                    checkOutput("core_plaintext", core_plaintext, curPt);
                    loadCnt++;
                end else if (prevLoad) begin
                    checkNumber("load_cycles", loadCnt, TB_LOAD);
                end
                prevLoad = core_load;
                if (out_valid) begin
                    if (ctQ.size() == 0) begin
                        checkFlag("spurious_out_valid", out_valid, 1'b0);
                    end else if (out_ready) begin
                        checkOutput("out_block", out_block, ctQ.pop_front());
                    end else begin
                        checkOutput("out_block_hold", out_block, ctQ[0]);
                        checkFlag("hold_in_ready", in_ready, 1'b0);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        reset      = 1'b1;
        iv_wr      = 1'b0;
        iv         = '0;
        key        = KAT_KEY;
        in_valid   = 1'b0;
        in_block   = '0;
        out_ready  = 1'b1;
        modelChain = '0;
        repeat (3) @(negedge clk);
        checkFlag("reset_busy", busy, 1'b0);
        checkFlag("reset_core_load", core_load, 1'b0);
        checkFlag("reset_out_valid", out_valid, 1'b0);
        checkFlag("reset_err", err_timeout, 1'b0);
        checkOutput("reset_out_block", out_block, '0);
        checkOutput("reset_core_plaintext", core_plaintext, '0);
        reset = 1'b0;
        @(negedge clk);
        checkFlag("in_ready_after_reset", in_ready, 1'b1);

        $display("[TB] known-answer block, iv=0");
        applyStimulus(KAT_PT, 1'b1, '0, 1'b1);
        waitIdle();
        $display("[TB] second block chained on previous ciphertext");
        applyStimulus(KAT_PT, 1'b0, '0, 1'b1);
        waitIdle();

        $display("[TB] output back-pressure");
        out_ready = 1'b0;
        applyStimulus(rand128(), 1'b0, '0, 1'b1);
        waitOutValid();
        repeat (10) begin
            @(negedge clk);
            checkFlag("stall_out_valid", out_valid, 1'b1);
            checkFlag("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        waitIdle();

        $display("[TB] core never completes");
        coreDead = 1'b1;
        applyStimulus(rand128(), 1'b0, '0, 1'b0);
        waitLoadFall();
        cyc = 0;
        while (!err_timeout && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checkNumber("timeout_cycles", cyc, TB_TIMEOUT);
        checkFlag("timeout_idle", busy, 1'b0);
        checkFlag("timeout_in_ready", in_ready, 1'b1);
        checkFlag("timeout_no_out", out_valid, 1'b0);
        @(negedge clk);
        checkFlag("err_sticky", err_timeout, 1'b1);
        coreDead = 1'b0;
        writeIv('0);
        checkFlag("err_cleared_by_iv_wr", err_timeout, 1'b0);

        $display("[TB] asynchronous reset mid-WAIT");
        applyStimulus(rand128(), 1'b0, '0, 1'b0);
        waitLoadFall();
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkFlag("areset_busy", busy, 1'b0);
        checkFlag("areset_core_load", core_load, 1'b0);
        checkFlag("areset_out_valid", out_valid, 1'b0);
        checkFlag("areset_in_ready", in_ready, 1'b1);
        checkOutput("areset_out_block", out_block, '0);
        checkOutput("areset_core_plaintext", core_plaintext, '0);
        modelChain = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkFlag("in_ready_after_areset", in_ready, 1'b1);
        applyStimulus(KAT_PT, 1'b1, '0, 1'b1);
        waitIdle();

        $display("[TB] stale done carried into WAIT");
        staleMode = 1'b1;
        doneDelay = 10;
        applyStimulus(rand128(), 1'b0, '0, 1'b1);
        waitIdle();

        $display("[TB] randomized blocks");
        for (int i = 0; i < 12; i++) begin
            int stall;
            key       = rand128();
            doneDelay = $urandom_range(3, 40);
            staleMode = 1'b1 & $urandom_range(0, 1);
            stall     = $urandom_range(0, 6);
            if (stall > 0) out_ready = 1'b0;
            applyStimulus(rand128(), 1'b1 & $urandom_range(0, 1), rand128(), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (busy) begin
                iv_wr = 1'b1;
                iv    = rand128();
                @(negedge clk);
                iv_wr = 1'b0;
            end
            if (stall > 0) begin
                waitOutValid();
                repeat (stall) @(negedge clk);
                out_ready = 1'b1;
            end
            waitIdle();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
